// File: rtl/pll_pkg.sv
// Shared types and helpers for the all-digital PLL loop controller and its DCO model.
package pll_pkg;

    localparam int PLL_LAMBDA_W   = 8;
    localparam int PLL_LAMBDA_MID = 1 << (PLL_LAMBDA_W - 1);
    localparam int PLL_ALPHA_INIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COARSE,
        ST_FINE,
        ST_LOCKED
    } pll_state_e;

    // Moves v by d (down when dn=1), clamping to 0..vmax instead of wrapping.
    function automatic int sat_step(input int v, input int d, input logic dn, input int vmax);
        if (dn)
            return (v < d) ? 0 : v - d;
        return (v + d > vmax) ? vmax : v + d;
    endfunction

endpackage

// File: rtl/pll_lock_det.sv
// Lock/unlock qualifier: counts sign changes at minimum gain and same-direction runs while locked.
module pll_lock_det #(
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_RUN = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_fine_pd,
    input  logic i_locked_pd,
    input  logic i_alpha_zero,
    input  logic i_dir,
    input  logic i_prev_dir,
    output logic o_lock_hit,
    output logic o_unlock_hit
);

    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam int RW = $clog2(UNLOCK_RUN + 1);

    logic [LW-1:0] r_lock_cnt;
    logic [RW-1:0] r_run_cnt;
    logic          w_change;
    logic [LW-1:0] w_lock_nx;
    logic [RW-1:0] w_run_nx;

    assign w_change  = i_dir != i_prev_dir;
    assign w_lock_nx = r_lock_cnt + LW'(1);
    // A direction change starts a new run that already contains the current decision.
    assign w_run_nx  = w_change ? RW'(1) : r_run_cnt + RW'(1);

    assign o_lock_hit   = i_fine_pd && i_alpha_zero && w_change && (w_lock_nx == LW'(LOCK_CNT));
    assign o_unlock_hit = i_locked_pd && (w_run_nx == RW'(UNLOCK_RUN));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_lock_cnt <= '0;
            r_run_cnt  <= '0;
        end else begin
            if (i_fine_pd && i_alpha_zero)
                r_lock_cnt <= (w_change && !o_lock_hit) ? w_lock_nx : '0;
            if (i_locked_pd)
                r_run_cnt <= o_unlock_hit ? '0 : w_run_nx;
        end
    end

endmodule

// File: rtl/pll_loop_ctrl.sv
// ADPLL loop controller: coarse binary search, shrinking-gain fine tracking, lock monitor.
// Define PLL_LOCK_DEADBAND_EN to move lambda in LOCKED only on two same-direction decisions.
module pll_loop_ctrl
    import pll_pkg::*;
#(
    parameter int LAMBDA_W   = PLL_LAMBDA_W,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_RUN = 4,
    parameter int ALPHA_INIT = PLL_ALPHA_INIT
) (
    input  logic                i_clk_ref,
    input  logic                i_rst,
    input  logic                i_enable,
    input  logic                i_pd_valid,
    input  logic                i_lead_lag,
    output logic [LAMBDA_W-1:0] o_lambda,
    output logic [1:0]          o_alpha,
    output logic                o_lock
);

    localparam int LMAX = (1 << LAMBDA_W) - 1;
    localparam logic [LAMBDA_W-1:0] LMID  = LAMBDA_W'(1) << (LAMBDA_W - 1);
    localparam logic [LAMBDA_W-2:0] STEP0 = (LAMBDA_W-1)'(1) << (LAMBDA_W - 2);

    pll_state_e          r_state;
    logic [LAMBDA_W-1:0] r_lambda;
    logic [LAMBDA_W-2:0] r_step;
    logic [1:0]          r_alpha;
    logic                r_lock;
    logic                r_prev_dir;

    logic [LAMBDA_W-1:0] w_delta;
    logic [LAMBDA_W-1:0] w_lambda_nx;
    logic                w_move;
    logic                w_pd;
    logic                w_lock_hit;
    logic                w_unlock_hit;

    assign w_pd = i_enable && i_pd_valid;

    always_comb begin
        w_delta = LAMBDA_W'(1);
        case (r_state)
            ST_COARSE: w_delta = {1'b0, r_step};
            ST_FINE:   w_delta = LAMBDA_W'(1) << r_alpha;
            default:   w_delta = LAMBDA_W'(1);
        endcase
        w_lambda_nx = LAMBDA_W'(sat_step(int'(r_lambda), int'(w_delta), i_lead_lag, LMAX));
    end

`ifdef PLL_LOCK_DEADBAND_EN
    assign w_move = (i_lead_lag == r_prev_dir);
`else
    assign w_move = 1'b1;
`endif

    pll_lock_det #(
        .LOCK_CNT  (LOCK_CNT),
        .UNLOCK_RUN(UNLOCK_RUN)
    ) u_lock_det (
        .i_clk       (i_clk_ref),
        .i_rst       (i_rst),
        .i_clr       (!i_enable || (r_state == ST_IDLE)),
        .i_fine_pd   (w_pd && (r_state == ST_FINE)),
        .i_locked_pd (w_pd && (r_state == ST_LOCKED)),
        .i_alpha_zero(r_alpha == 2'd0),
        .i_dir       (i_lead_lag),
        .i_prev_dir  (r_prev_dir),
        .o_lock_hit  (w_lock_hit),
        .o_unlock_hit(w_unlock_hit)
    );

    always_ff @(posedge i_clk_ref) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_lambda   <= LMID;
            r_step     <= STEP0;
            r_alpha    <= 2'(ALPHA_INIT);
            r_lock     <= 1'b0;
            r_prev_dir <= 1'b0;
        end else if (!i_enable) begin
            r_state <= ST_IDLE;
            r_lock  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state  <= ST_COARSE;
                    r_lambda <= LMID;
                    r_step   <= STEP0;
                end
                ST_COARSE: if (i_pd_valid) begin
                    r_lambda   <= w_lambda_nx;
                    r_prev_dir <= i_lead_lag;
                    r_step     <= r_step >> 1;
                    if (r_step == (LAMBDA_W-1)'(1)) begin
                        r_state <= ST_FINE;
                        r_alpha <= 2'(ALPHA_INIT);
                    end
                end
                ST_FINE: if (i_pd_valid) begin
                    r_lambda   <= w_lambda_nx;
                    r_prev_dir <= i_lead_lag;
                    if (i_lead_lag != r_prev_dir && r_alpha != 2'd0)
                        r_alpha <= r_alpha - 2'd1;
                    if (w_lock_hit) begin
                        r_state <= ST_LOCKED;
                        r_lock  <= 1'b1;
                    end
                end
                ST_LOCKED: if (i_pd_valid) begin
                    if (w_move)
                        r_lambda <= w_lambda_nx;
                    r_prev_dir <= i_lead_lag;
                    if (w_unlock_hit) begin
                        r_state <= ST_FINE;
                        r_lock  <= 1'b0;
                        r_alpha <= 2'(ALPHA_INIT);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_lambda = r_lambda;
    assign o_alpha  = r_alpha;
    assign o_lock   = r_lock;

endmodule

// File: tb/tb_pll_loop_ctrl.sv
// Self-checking bench for pll_loop_ctrl: directed test-plan sequences plus a randomized target-tracking run.
module tb_pll_loop_ctrl;

    logic       clk = 1'b0;
    logic       tb_rst = 1'b1, tb_en = 1'b0, tb_pd = 1'b0, tb_dir = 1'b0;
    logic [7:0] o_lambda;
    logic [1:0] o_alpha;
    logic       o_lock;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    pll_loop_ctrl dut (
        .i_clk_ref (clk),
        .i_rst     (tb_rst),
        .i_enable  (tb_en),
        .i_pd_valid(tb_pd),
        .i_lead_lag(tb_dir),
        .o_lambda  (o_lambda),
        .o_alpha   (o_alpha),
        .o_lock    (o_lock)
    );

    // Reference model: mode is 0 idle, 1 searching, 2 tracking, 3 locked.
    int m_mode, m_lambda, m_step, m_alpha, m_lock, m_prev, m_changes, m_run;

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : (v > 255) ? 255 : v;
    endfunction

    task automatic model_step(input bit r, input bit en, input bit pd, input bit dir);
        int sgn;
        bit flip;
        sgn  = dir ? -1 : 1;
        flip = (dir != m_prev);
        if (r) begin
            m_mode = 0; m_lambda = 128; m_step = 64; m_alpha = 2; m_lock = 0;
            m_prev = 0; m_changes = 0; m_run = 0;
        end else if (!en) begin
            m_mode = 0; m_lock = 0; m_changes = 0; m_run = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_lambda = 128; m_step = 64;
        end else if (pd) begin
            if (m_mode == 1) begin
                m_lambda = clamp(m_lambda + sgn * m_step);
                if (m_step == 1) begin m_mode = 2; m_alpha = 2; end
                m_step = m_step / 2;
            end else if (m_mode == 2) begin
                m_lambda = clamp(m_lambda + sgn * (2 ** m_alpha));
                if (m_alpha > 0) begin
                    if (flip) m_alpha--;
                end else begin
                    m_changes = flip ? m_changes + 1 : 0;
                    if (m_changes == 8) begin m_mode = 3; m_lock = 1; m_changes = 0; end
                end
            end else begin
                m_run = flip ? 1 : m_run + 1;
`ifdef PLL_LOCK_DEADBAND_EN
                if (!flip) m_lambda = clamp(m_lambda + sgn);
`else
                m_lambda = clamp(m_lambda + sgn);
`endif
                if (m_run == 4) begin m_mode = 2; m_alpha = 2; m_lock = 0; m_run = 0; end
            end
            m_prev = dir;
        end
    endtask

    task automatic cyc(input bit r, input bit en, input bit pd, input bit dir);
        tb_rst = r; tb_en = en; tb_pd = pd; tb_dir = dir;
        @(posedge clk);
        model_step(r, en, pd, dir);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_lambda", int'(o_lambda), m_lambda);
            chk("model_alpha", int'(o_alpha), m_alpha);
            chk("model_lock", int'(o_lock), m_lock);
        end
    end

    int lead_tbl [7] = '{64, 32, 16, 8, 4, 2, 1};
    int lag_tbl  [7] = '{192, 224, 240, 248, 252, 254, 255};

    task automatic coarse(input bit dir);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 1, 1, dir);
    endtask

    task automatic alternate10();
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, (i % 2) == 0);
    endtask

    initial begin
        int tgt;
        bit d;
        cyc(1, 0, 0, 0);
        chk_on = 1'b1;
        chk("rst_lambda", int'(o_lambda), 128);
        chk("rst_alpha", int'(o_alpha), 2);
        chk("rst_lock", int'(o_lock), 0);

        // Coarse search, all lead: halving ladder down, then saturate at 0.
        cyc(0, 1, 0, 0);
        chk("enable_lambda", int'(o_lambda), 128);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 1, 1, 1);
            chk("coarse_lead", int'(o_lambda), lead_tbl[i]);
        end
        chk("lead_fine_alpha", int'(o_alpha), 2);
        cyc(0, 1, 1, 1);
        chk("lead_sat0", int'(o_lambda), 0);

        // Coarse search, all lag: ladder up, then saturate at 255.
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 1, 1, 0);
            chk("coarse_lag", int'(o_lambda), lag_tbl[i]);
        end
        cyc(0, 1, 1, 0);
        chk("lag_sat255", int'(o_lambda), 255);
        chk("lag_alpha", int'(o_alpha), 2);

        // Lock acquisition with alternating decisions; lambda after the 0 above the sat step stays 255.
        cyc(0, 1, 1, 1);
        chk("alt1_alpha", int'(o_alpha), 1);
        chk("alt1_lambda", int'(o_lambda), 251);
        cyc(0, 1, 1, 0);
        chk("alt2_alpha", int'(o_alpha), 0);
        chk("alt2_lambda", int'(o_lambda), 253);
        for (int i = 0; i < 7; i++) cyc(0, 1, 1, (i % 2) == 0);
        chk("pre_lock", int'(o_lock), 0);
        cyc(0, 1, 1, 0);
        chk("lock_set", int'(o_lock), 1);
        chk("lock_lambda", int'(o_lambda), 253);
        cyc(0, 1, 1, 1);
`ifdef PLL_LOCK_DEADBAND_EN
        chk("locked_dither_hold", int'(o_lambda), 253);
`else
        chk("locked_dither", int'(o_lambda), 252);
`endif
        cyc(0, 1, 1, 0);
        chk("locked_dither_back", int'(o_lambda), 253);

        // Unlock on a run of four same-direction decisions.
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1);
        chk("still_locked", int'(o_lock), 1);
        cyc(0, 1, 1, 1);
        chk("unlock", int'(o_lock), 0);
        chk("unlock_alpha", int'(o_alpha), 2);
`ifdef PLL_LOCK_DEADBAND_EN
        chk("unlock_lambda", int'(o_lambda), 250);
`else
        chk("unlock_lambda", int'(o_lambda), 249);
`endif

        // enable drop wins over a simultaneous decision; re-enable restarts at mid-scale.
        cyc(0, 0, 1, 1);
`ifdef PLL_LOCK_DEADBAND_EN
        chk("disable_hold", int'(o_lambda), 250);
`else
        chk("disable_hold", int'(o_lambda), 249);
`endif
        chk("disable_lock", int'(o_lock), 0);
        cyc(0, 1, 0, 0);
        chk("reenable_mid", int'(o_lambda), 128);

        // Reset while locked together with a decision.
        for (int i = 0; i < 7; i++) cyc(0, 1, 1, 0);
        alternate10();
        chk("relock", int'(o_lock), 1);
        cyc(1, 1, 1, 1);
        chk("rst_locked_lambda", int'(o_lambda), 128);
        chk("rst_locked_alpha", int'(o_alpha), 2);
        chk("rst_locked_lock", int'(o_lock), 0);

        // Random tracking of a moving target with noise, enable drops and rare resets.
        tgt = 100;
        for (int c = 0; c < 4000; c++) begin
            if (c % 400 == 0) begin
                case ($urandom_range(0, 3))
                    0: tgt = 0;
                    1: tgt = 255;
                    default: tgt = int'($urandom_range(10, 245));
                endcase
            end
            if (m_lambda > tgt) d = 1'b1;
            else if (m_lambda < tgt) d = 1'b0;
            else d = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) d = ~d;
            cyc($urandom_range(0, 999) == 0, $urandom_range(0, 299) != 0,
                $urandom_range(0, 3) != 0, d);
        end

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
